lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron. It sits directly downstream of the synapse stage: it consumes the delayed spike pulses from N_IN synapses, integrates them into a membrane potential and emits a one-cycle output spike. That spike drives the next layer of synapses in the oscillator network. A constant bias current lets a neuron self-oscillate with no input.

Parameters:
N_IN, 4, number of synaptic spike inputs
W, 8, membrane potential width (unsigned)
THRESH, 64, firing threshold; fire when v_next >= THRESH
WEIGHT, 16, magnitude added or subtracted per input spike
INH_MASK, 0, N_IN-bit mask; a 1 marks that input as inhibitory
LEAK_SHIFT, 3, leak term is v >> LEAK_SHIFT
BIAS, 0, constant added every integrating cycle
REFRACT, 4, refractory cycles after a fire, 0..15

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  reset, synchronous, active-high
enable  in  1  integration enable; low freezes v while in INTEGRATE
syn_in  in  N_IN  synapse spike levels, sampled each clk
spike_out  out  1  registered one-cycle fire pulse
v_mem  out  W  current membrane potential
state  out  2  FSM state: 0 INTEGRATE, 1 FIRE, 2 REFRACT
spike_count  out  8  total fires since reset, wraps 255 -> 0

Behaviour:
- Reset state, sampled at clk edge with reset=1: state=INTEGRATE, v_mem=0, spike_out=0, spike_count=0, refractory counter=0. Reset overrides every other input, including mid-FIRE and mid-REFRACT.
- n_exc = popcount(syn_in & ~INH_MASK); n_inh = popcount(syn_in & INH_MASK).
- v_next = v - (v >> LEAK_SHIFT) + BIAS + WEIGHT*n_exc - WEIGHT*n_inh.
  - Leak is applied to the current v first.
  - Computed signed, width W+clog2(N_IN)+clog2(WEIGHT)+2, so there is no intermediate overflow.
  - Saturated to [0, 2^W-1] before any compare or store.
- INTEGRATE, enable=1:
  - v_mem <= sat(v_next).
  - If sat(v_next) >= THRESH: state <= FIRE, spike_out <= 1, spike_count <= spike_count+1.
  - Latency: input sampled at edge k gives spike_out high during cycle k..k+1.
- INTEGRATE, enable=0: v_mem and state hold, syn_in is ignored, spike_out=0.
- FIRE, exactly one cycle, independent of enable and syn_in:
  - v_mem <= 0, spike_out <= 0.
  - If REFRACT=0: state <= INTEGRATE. Otherwise state <= REFRACT, counter <= REFRACT-1.
- REFRACT, independent of enable:
  - syn_in ignored, v_mem held at 0, spike_out=0.
  - If counter=0: state <= INTEGRATE, else counter decrements.
  - Inputs are therefore blocked for exactly REFRACT cycles after the FIRE cycle.
- spike_out is never high two consecutive cycles. The minimum spacing between spikes is REFRACT+2 cycles.
- The leak floor leaves a residual: v stops decaying once v >> LEAK_SHIFT = 0, i.e. v < 2^LEAK_SHIFT. This is intended.
- Simultaneous excitatory and inhibitory inputs are summed in the same cycle, with no priority.
- Illegal state encoding 3 returns to INTEGRATE with v_mem=0.

Decomposition:
- Shared package neuron_pkg:
  - state encodings ST_INTEGRATE, ST_FIRE, ST_REFRACT;
  - default W and THRESH constants;
  - a saturating-clamp function reused by other neuron variants.
- One sub-module, spike_popcount: parameterised N_IN, purely combinational, output width clog2(N_IN+1). It is instantiated twice, once for excitatory and once for inhibitory inputs.

Test Plan:
1. Default parameters, assert reset 2 cycles mid-stream -> next cycle v_mem=0, state=0, spike_out=0, spike_count=0.
2. Single excitatory pulse syn_in=0001 for one cycle -> v_mem sequence 16,14,13,12,11,10,9,8,7,7,7; no spike_out.
3. syn_in=1111 for one cycle from v=0 -> v_next=64, spike_out high for exactly 1 cycle, spike_count=1. Then v_mem=0 and state=REFRACT for 4 cycles with syn_in=1111 held and ignored. Integration resumes on the 6th cycle after the triggering edge.
4. INH_MASK=1000, v=0, syn_in=1000 -> v_mem stays 0 (floor saturation). With THRESH=255 and v=250, syn_in=0111 -> v_next clamps to 255 and fires.
5. BIAS=8, syn_in=0 -> v_mem climbs 8,15,22,28,33,...; spike_out fires at a fixed period P, identical across 3 consecutive spikes. With enable=0 for 10 cycles mid-climb, v_mem freezes and the fire is delayed by exactly 10 cycles.
6. Assert reset during REFRACT, then during FIRE -> state=INTEGRATE, spike_out=0, v_mem=0 the next cycle. After 256 fires, spike_count wraps to 0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the spiking-neuron family: FSM encodings, default
// sizing and the saturating clamp every neuron variant applies before storing.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } state_t;

  localparam int DEF_W      = 8;
  localparam int DEF_THRESH = 64;

  // Clamp a signed intermediate into [0, max_v].
  function automatic logic [31:0] sat_clamp(input logic signed [31:0] x,
                                            input logic [31:0] max_v);
    logic [31:0] r;
    if (x < 0)
      r = '0;
    else if ($unsigned(x) > max_v)
      r = max_v;
    else
      r = $unsigned(x);
    return r;
  endfunction

endpackage

// File: rtl/spike_popcount.sv
// Combinational count of asserted spike lines.
module spike_popcount #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0]            i_bits,
  output logic [$clog2(N_IN+1)-1:0]  o_count
);

  localparam int CW = $clog2(N_IN + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N_IN; i++)
      o_count = o_count + CW'(i_bits[i]);
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates synapse spikes into a saturating
// membrane potential, fires a one-cycle pulse, then holds off for REFRACT cycles.
module lif_neuron
  import neuron_pkg::*;
#(
  parameter int              N_IN       = 4,
  parameter int              W          = DEF_W,
  parameter int              THRESH     = DEF_THRESH,
  parameter int              WEIGHT     = 16,
  parameter logic [N_IN-1:0] INH_MASK   = '0,
  parameter int              LEAK_SHIFT = 3,
  parameter int              BIAS       = 0,
  parameter int              REFRACT    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_IN-1:0] syn_in,
  output logic            spike_out,
  output logic [W-1:0]    v_mem,
  output logic [1:0]      state,
  output logic [7:0]      spike_count
);

  localparam int CNT_W = $clog2(N_IN + 1);
  // Wide enough that leak, bias and every weighted input sum without wrap.
  localparam int CW    = W + $clog2(N_IN) + $clog2(WEIGHT) + 2;
  localparam logic [3:0] REFR_LOAD = 4'(REFRACT - 1);

  state_t           r_state;
  logic [W-1:0]     r_v;
  logic             r_spike;
  logic [7:0]       r_count;
  logic [3:0]       r_refr;

  logic [N_IN-1:0]  w_exc_bits;
  logic [N_IN-1:0]  w_inh_bits;
  logic [CNT_W-1:0] w_n_exc;
  logic [CNT_W-1:0] w_n_inh;
  logic signed [CW-1:0] w_v_next;
  logic [W-1:0]     w_v_sat;
  logic [31:0]      w_v_wide;
  logic             w_fire;

  assign w_exc_bits = syn_in & ~INH_MASK;
  assign w_inh_bits = syn_in & INH_MASK;

  spike_popcount #(.N_IN(N_IN)) u_pc_exc (.i_bits(w_exc_bits), .o_count(w_n_exc));
  spike_popcount #(.N_IN(N_IN)) u_pc_inh (.i_bits(w_inh_bits), .o_count(w_n_inh));

  // Leak comes off the current potential before new charge is added.
  always_comb begin
    w_v_next = CW'(r_v) - CW'(r_v >> LEAK_SHIFT) + CW'(BIAS)
             + CW'(WEIGHT) * CW'(w_n_exc) - CW'(WEIGHT) * CW'(w_n_inh);
    w_v_sat  = W'(sat_clamp(32'(w_v_next), (32'd1 << W) - 32'd1));
    w_v_wide = 32'(w_v_sat);
    w_fire   = (w_v_wide >= 32'(THRESH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INTEGRATE;
      r_v     <= '0;
      r_spike <= 1'b0;
      r_count <= '0;
      r_refr  <= '0;
    end else begin
      r_spike <= 1'b0;
      case (r_state)
        ST_INTEGRATE: begin
          if (enable) begin
            r_v <= w_v_sat;
            if (w_fire) begin
              r_state <= ST_FIRE;
              r_spike <= 1'b1;
              r_count <= r_count + 8'd1;
            end
          end
        end
        ST_FIRE: begin
          r_v <= '0;
          if (REFRACT == 0) begin
            r_state <= ST_INTEGRATE;
          end else begin
            r_state <= ST_REFRACT;
            r_refr  <= REFR_LOAD;
          end
        end
        ST_REFRACT: begin
          r_v <= '0;
          if (r_refr == 4'd0)
            r_state <= ST_INTEGRATE;
          else
            r_refr <= r_refr - 4'd1;
        end
        default: begin
          r_state <= ST_INTEGRATE;
          r_v     <= '0;
        end
      endcase
    end
  end

  assign spike_out   = r_spike;
  assign v_mem       = r_v;
  assign state       = r_state;
  assign spike_count = r_count;

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron: three parameterisations driven with directed
// vectors; expected outputs are queued per cycle and checked by a monitor.
module tb_lif_neuron;

  localparam int M_SP  = 1;
  localparam int M_V   = 2;
  localparam int M_ST  = 4;
  localparam int M_CNT = 8;
  localparam int M_ALL = 15;

  logic       clk;
  logic       rst [3];
  logic       en  [3];
  logic [3:0] syn [3];
  logic       spk [3];
  logic [7:0] vm  [3];
  logic [1:0] st  [3];
  logic [7:0] sc  [3];

  typedef struct {
    int         tag;
    int         d;
    int         mask;
    string      nm;
    logic       sp;
    logic [7:0] v;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  bit   mon_ok;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int leak_seq [10] = '{14, 13, 12, 11, 10, 9, 8, 7, 7, 7};
  int inh_seq  [8]  = '{48, 90, 127, 160, 188, 213, 235, 254};
  int bias_seq [21] = '{8, 15, 22, 28, 33, 37, 41, 44, 47, 50, 52,
                        54, 56, 57, 58, 59, 60, 61, 62, 63, 64};

  lif_neuron u_dut0 (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .syn_in(syn[0]),
    .spike_out(spk[0]), .v_mem(vm[0]), .state(st[0]), .spike_count(sc[0])
  );

  lif_neuron #(.INH_MASK(4'b1000), .THRESH(255)) u_dut1 (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .syn_in(syn[1]),
    .spike_out(spk[1]), .v_mem(vm[1]), .state(st[1]), .spike_count(sc[1])
  );

  lif_neuron #(.BIAS(8)) u_dut2 (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .syn_in(syn[2]),
    .spike_out(spk[2]), .v_mem(vm[2]), .state(st[2]), .spike_count(sc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the outputs produced by the next rising edge.
  task automatic ex(input int d, input string nm, input int mask, input logic sp,
                    input logic [7:0] v, input logic [1:0] s, input logic [7:0] cnt);
    exp_t e;
    e.tag = cyc + 1; e.d = d; e.mask = mask; e.nm = nm;
    e.sp = sp; e.v = v; e.st = s; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
      mon_e  = sbq.pop_front();
      mon_ok = (mon_e.tag == cyc);
      if ((mon_e.mask & M_SP)  != 0 && spk[mon_e.d] !== mon_e.sp)  mon_ok = 1'b0;
      if ((mon_e.mask & M_V)   != 0 && vm[mon_e.d]  !== mon_e.v)   mon_ok = 1'b0;
      if ((mon_e.mask & M_ST)  != 0 && st[mon_e.d]  !== mon_e.st)  mon_ok = 1'b0;
      if ((mon_e.mask & M_CNT) != 0 && sc[mon_e.d]  !== mon_e.cnt) mon_ok = 1'b0;
      n_cmp++;
      if (!mon_ok) begin
        n_bad++;
        $display("FAIL %s dut%0d cyc%0d: got sp=%0b v=%0d st=%0d cnt=%0d, want sp=%0b v=%0d st=%0d cnt=%0d (mask %0h)",
                 mon_e.nm, mon_e.d, cyc, spk[mon_e.d], vm[mon_e.d], st[mon_e.d], sc[mon_e.d],
                 mon_e.sp, mon_e.v, mon_e.st, mon_e.cnt, mon_e.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; en[d] = 1'b0; syn[d] = 4'b0000;
    end
    nx();
    for (int d = 0; d < 3; d++) ex(d, "reset_state", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0);
    nx();

    // Reset mid-stream, with a would-fire input present.
    rst[0] = 1'b0; en[0] = 1'b1; syn[0] = 4'b0001;
    ex(0, "t1_pre", M_ALL, 1'b0, 8'd16, 2'd0, 8'd0); nx();
    ex(0, "t1_pre", M_V, 1'b0, 8'd30, 2'd0, 8'd0); nx();
    rst[0] = 1'b1; syn[0] = 4'b1111;
    ex(0, "t1_rst", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    ex(0, "t1_rst", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    rst[0] = 1'b0; syn[0] = 4'b0000;
    ex(0, "t1_post", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();

    // Single pulse then leak down to the residual floor.
    syn[0] = 4'b0001;
    ex(0, "t2_pulse", M_ALL, 1'b0, 8'd16, 2'd0, 8'd0); nx();
    syn[0] = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      ex(0, "t2_leak", M_ALL, 1'b0, 8'(leak_seq[i]), 2'd0, 8'd0); nx();
    end
    rst[0] = 1'b1;
    ex(0, "t2_clr", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    rst[0] = 1'b0;

    // Exact-threshold fire, refractory window with inputs held.
    syn[0] = 4'b1111;
    ex(0, "t3_fire", M_ALL, 1'b1, 8'd64, 2'd1, 8'd1); nx();
    ex(0, "t3_fire_cyc", M_ALL, 1'b0, 8'd0, 2'd2, 8'd1); nx();
    for (int i = 0; i < 3; i++) begin
      ex(0, "t3_refract", M_ALL, 1'b0, 8'd0, 2'd2, 8'd1); nx();
    end
    ex(0, "t3_back", M_ALL, 1'b0, 8'd0, 2'd0, 8'd1); nx();
    ex(0, "t3_refire", M_ALL, 1'b1, 8'd64, 2'd1, 8'd2); nx();

    // Reset while in FIRE, then while in REFRACT.
    rst[0] = 1'b1;
    ex(0, "t6_rst_fire", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    rst[0] = 1'b0;
    ex(0, "t6_fire", M_ALL, 1'b1, 8'd64, 2'd1, 8'd1); nx();
    ex(0, "t6_refr", M_ALL, 1'b0, 8'd0, 2'd2, 8'd1); nx();
    ex(0, "t6_refr", M_ALL, 1'b0, 8'd0, 2'd2, 8'd1); nx();
    rst[0] = 1'b1;
    ex(0, "t6_rst_refr", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    rst[0] = 1'b0; syn[0] = 4'b0000;
    ex(0, "t6_post", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();

    // 257 fires at minimum spacing: count wraps 255 -> 0 -> 1.
    syn[0] = 4'b1111;
    for (int k = 1; k <= 257; k++) begin
      ex(0, "wrap_fire", M_ALL, 1'b1, 8'd64, 2'd1, 8'(k % 256)); nx();
      ex(0, "wrap_gap", M_SP | M_ST | M_CNT, 1'b0, 8'd0, 2'd2, 8'(k % 256)); nx();
      for (int j = 0; j < 3; j++) begin
        ex(0, "wrap_gap", M_SP | M_ST, 1'b0, 8'd0, 2'd2, 8'd0); nx();
      end
      ex(0, "wrap_gap", M_SP | M_ST, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    end
    syn[0] = 4'b0000;

    // Inhibitory floor and top-end saturation.
    rst[1] = 1'b0; en[1] = 1'b1; syn[1] = 4'b1000;
    ex(1, "t4_inh_floor", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    syn[1] = 4'b1001;
    ex(1, "t4_mixed", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    syn[1] = 4'b0001;
    ex(1, "t4_exc", M_ALL, 1'b0, 8'd16, 2'd0, 8'd0); nx();
    syn[1] = 4'b1000;
    ex(1, "t4_inh_under", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    syn[1] = 4'b0111;
    for (int i = 0; i < 8; i++) begin
      ex(1, "t4_climb", M_ALL, 1'b0, 8'(inh_seq[i]), 2'd0, 8'd0); nx();
    end
    ex(1, "t4_sat_fire", M_ALL, 1'b1, 8'd255, 2'd1, 8'd1); nx();
    ex(1, "t4_after", M_ALL, 1'b0, 8'd0, 2'd2, 8'd1); nx();
    syn[1] = 4'b0000;

    // Bias-driven self-oscillation: fires at edges 21, 47, 73 (period 26).
    rst[2] = 1'b0; en[2] = 1'b1; syn[2] = 4'b0000;
    for (int e = 1; e <= 73; e++) begin
      if (e <= 21)
        ex(2, "t5_climb", M_SP | M_V, (e == 21), 8'(bias_seq[e-1]), 2'd0, 8'd0);
      else
        ex(2, "t5_period", M_SP | ((e == 73) ? M_CNT : 0), (e == 47 || e == 73),
           8'd0, 2'd0, 8'd3);
      nx();
    end

    // Enable low for 10 cycles mid-climb delays the fire by exactly 10.
    rst[2] = 1'b1;
    ex(2, "t5_rst", M_ALL, 1'b0, 8'd0, 2'd0, 8'd0); nx();
    rst[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ex(2, "t5_pre_freeze", M_SP | M_V, 1'b0, 8'(bias_seq[i]), 2'd0, 8'd0); nx();
    end
    en[2] = 1'b0; syn[2] = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      ex(2, "t5_freeze", M_SP | M_V | M_ST, 1'b0, 8'd33, 2'd0, 8'd0); nx();
    end
    en[2] = 1'b1; syn[2] = 4'b0000;
    for (int i = 5; i < 21; i++) begin
      ex(2, "t5_resume", M_SP | M_V, (i == 20), 8'(bias_seq[i]), 2'd0, 8'd0); nx();
    end

    nx(); nx(); nx();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expectations left unchecked, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
